// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, memory-stage state encoding and pipeline
//                constants for the 16-bit 5-stage pipelined cpu.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int CPU_DW          = 16;   // datapath / address width
  localparam int CPU_RW          = 4;    // register specifier width
  localparam int CPU_ACK_TIMEOUT = 255;  // dmem_ack wait limit in cycles

  // Memory access controller states
  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_BUSY   = 2'd1,
    MEM_HALTED = 2'd2
  } mem_state_e;

  // A bubble retires an all-zero instruction word with all strobes low
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

  // Opcode field (instr[15:12]) of the HLT instruction
  localparam logic [3:0]  OPC_HLT      = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_fsm
//  Description : Memory-stage controller. Runs the req/ack handshake with the
//                data memory, stalls the upstream pipe while an access is
//                outstanding, flags ack timeouts and tracks the halted state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_fsm
  import cpu_pkg::*;
#(
  parameter int DW          = CPU_DW,
  parameter int ACK_TIMEOUT = CPU_ACK_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic          ex_memread,
  input  logic          ex_memwrt,
  input  logic          ex_hlt,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_st_data,
  input  logic          dmem_ack,
  output logic          mem_stall,
  output logic          dmem_req,
  output logic          dmem_wr,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_err,
  output logic          retire,      // load a real instruction into WB this edge
  output logic          halt_enter   // the instruction retiring this edge is HLT
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  mem_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       req, stall, memop;

  assign memop = ex_valid & (ex_memread | ex_memwrt);

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state, handshake and stall decode; ack is only honoured in BUSY
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    req        = 1'b0;
    stall      = 1'b0;
    retire     = 1'b0;
    halt_enter = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (ex_valid) begin
          if (ex_hlt) begin
            retire     = 1'b1;
            halt_enter = 1'b1;
            state_d    = MEM_HALTED;
          end else if (memop) begin
            req        = 1'b1;
            stall      = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = MEM_BUSY;
          end else begin
            retire = 1'b1;
          end
        end
      end
      MEM_BUSY: begin
        req = 1'b1;
        if (dmem_ack) begin
          retire  = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          stall = 1'b1;
          // Saturate so a very long wait can never re-arm the comparison
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) err_d = 1'b1;
        end
      end
      MEM_HALTED: begin
        state_d = MEM_HALTED;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  // Request fields come straight from the EX/MEM bundle, which upstream
  // holds frozen while we stall; reset forces every output low at once.
  assign dmem_req   = req & rst_n;
  assign mem_stall  = stall & rst_n;
  assign dmem_wr    = dmem_req & ex_memwrt;
  assign dmem_addr  = dmem_req ? ex_alu : '0;
  assign dmem_wdata = dmem_req ? ex_st_data : '0;
  assign dmem_err   = err_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory stage plus MEM/WB pipeline register. Performs loads
//                and stores over a multi-cycle req/ack port and presents the
//                registered write-back bundle and retired-instruction count.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DW          = CPU_DW,
  parameter int RW          = CPU_RW,
  parameter int ACK_TIMEOUT = CPU_ACK_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [15:0]   ex_instr,
  input  logic          ex_regwrt,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_alu,
  input  logic          ex_memread,
  input  logic          ex_memwrt,
  input  logic [DW-1:0] ex_st_data,
  input  logic          ex_hlt,
  output logic          mem_stall,
  output logic          dmem_req,
  output logic          dmem_wr,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [15:0]   Instr_WB,
  output logic          RegWrt_WB,
  output logic [RW-1:0] Rd_WB,
  output logic [DW-1:0] RegWrt_Data_WB,
  output logic          MemRead_WB,
  output logic          MemWrt_WB,
  output logic [DW-1:0] MemAddr_WB,
  output logic [DW-1:0] MemWrt_Data_WB,
  output logic [DW-1:0] MemRead_Data_WB,
  output logic          hlt,
  output logic [31:0]   inst_count,
  output logic          dmem_err
);

  logic retire, halt_enter, is_read, is_write;

  logic [15:0]   instr_q, instr_d;
  logic          regwrt_q, regwrt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] regdata_q, regdata_d;
  logic          memread_q, memread_d;
  logic          memwrt_q, memwrt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          hlt_q, hlt_d;
  logic [31:0]   cnt_q, cnt_d;

  mem_access_fsm #(
    .DW          (DW),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_memwrt  (ex_memwrt),
    .ex_hlt     (ex_hlt),
    .ex_alu     (ex_alu),
    .ex_st_data (ex_st_data),
    .dmem_ack   (dmem_ack),
    .mem_stall  (mem_stall),
    .dmem_req   (dmem_req),
    .dmem_wr    (dmem_wr),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_err   (dmem_err),
    .retire     (retire),
    .halt_enter (halt_enter)
  );

  // A combined read+write request is treated as a write
  assign is_write = ex_memwrt;
  assign is_read  = ex_memread & ~ex_memwrt;

  // Next WB bundle: retiring instruction, or a bubble that holds the data
  always_comb begin
    instr_d   = BUBBLE_INSTR;
    regwrt_d  = 1'b0;
    memread_d = 1'b0;
    memwrt_d  = 1'b0;
    rd_d      = rd_q;
    regdata_d = regdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hlt_d     = hlt_q | halt_enter;
    cnt_d     = cnt_q;
    if (retire) begin
      instr_d   = ex_instr;
      regwrt_d  = ex_regwrt;
      rd_d      = ex_rd;
      memread_d = is_read;
      memwrt_d  = is_write;
      regdata_d = is_read ? dmem_rdata : ex_alu;
      addr_d    = ex_alu;
      wdata_d   = is_write ? ex_st_data : '0;
      rdata_d   = is_read ? dmem_rdata : '0;
      if (ex_regwrt | is_write | halt_enter) cnt_d = cnt_q + 32'd1;
    end
  end

  // MEM/WB pipeline register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      regwrt_q  <= 1'b0;
      rd_q      <= '0;
      regdata_q <= '0;
      memread_q <= 1'b0;
      memwrt_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hlt_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      instr_q   <= instr_d;
      regwrt_q  <= regwrt_d;
      rd_q      <= rd_d;
      regdata_q <= regdata_d;
      memread_q <= memread_d;
      memwrt_q  <= memwrt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hlt_q     <= hlt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Instr_WB        = instr_q;
  assign RegWrt_WB       = regwrt_q;
  assign Rd_WB           = rd_q;
  assign RegWrt_Data_WB  = regdata_q;
  assign MemRead_WB      = memread_q;
  assign MemWrt_WB       = memwrt_q;
  assign MemAddr_WB      = addr_q;
  assign MemWrt_Data_WB  = wdata_q;
  assign MemRead_Data_WB = rdata_q;
  assign hlt             = hlt_q;
  assign inst_count      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Scoreboard bench for mem_wb_stage with a behavioural
//                data-memory model and randomized instruction mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_regwrt, ex_memread, ex_memwrt, ex_hlt;
  logic [15:0] ex_instr, ex_alu, ex_st_data;
  logic [3:0]  ex_rd;
  logic        mem_stall, dmem_req, dmem_wr, dmem_ack, dmem_err;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] Instr_WB, RegWrt_Data_WB, MemAddr_WB, MemWrt_Data_WB, MemRead_Data_WB;
  logic        RegWrt_WB, MemRead_WB, MemWrt_WB, hlt;
  logic [3:0]  Rd_WB;
  logic [31:0] inst_count;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_regwrt(ex_regwrt), .ex_rd(ex_rd),
    .ex_alu(ex_alu), .ex_memread(ex_memread), .ex_memwrt(ex_memwrt),
    .ex_st_data(ex_st_data), .ex_hlt(ex_hlt),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .Instr_WB(Instr_WB), .RegWrt_WB(RegWrt_WB), .Rd_WB(Rd_WB),
    .RegWrt_Data_WB(RegWrt_Data_WB), .MemRead_WB(MemRead_WB), .MemWrt_WB(MemWrt_WB),
    .MemAddr_WB(MemAddr_WB), .MemWrt_Data_WB(MemWrt_Data_WB),
    .MemRead_Data_WB(MemRead_Data_WB), .hlt(hlt), .inst_count(inst_count),
    .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        regwrt;
    logic [3:0]  rd;
    logic [15:0] regdata;
    logic        mrd, mwr;
    logic [15:0] addr, wdata, rdata;
    logic        chk_a, chk_w, chk_r;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_m [logic [15:0]];   // data memory contents
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cnt_m    = 0;           // architectural retired count
  logic        err_m    = 0;           // sticky timeout expectation
  logic        hlt_m    = 0;
  logic [15:0] last_regdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] v;
    v = 16'($urandom_range(1, 32'hEFFF));
    return v;
  endfunction

  // Present one valid instruction; answer memory accesses after ack_dly BUSY cycles.
  // Starts and ends just after a rising edge.
  task automatic issue(input logic [15:0] instr, input logic regwrt, input logic [3:0] rd,
                       input logic [15:0] alu, input logic mrd, input logic mwr,
                       input logic [15:0] st, input logic is_hlt, input int ack_dly);
    exp_t        e;
    logic [15:0] rdv;
    int          noack;
    e.instr = instr; e.regwrt = regwrt; e.rd = rd; e.addr = alu;
    e.mrd = 1'b0; e.mwr = 1'b0; e.wdata = 16'h0; e.rdata = 16'h0; rdv = 16'h0;
    e.chk_a = mrd | mwr; e.chk_w = 1'b1; e.chk_r = 1'b1; e.regdata = alu;
    if (mwr) begin
      mem_m[alu] = st;
      e.mwr = 1'b1; e.wdata = st; e.chk_r = 1'b0;
    end else if (mrd) begin
      rdv = mem_m.exists(alu) ? mem_m[alu] : 16'($urandom);
      mem_m[alu] = rdv;
      e.mrd = 1'b1; e.regdata = rdv; e.rdata = rdv; e.chk_w = 1'b0;
    end
    if (is_hlt) hlt_m = 1'b1;
    if (regwrt | mwr | is_hlt) cnt_m = cnt_m + 1;
    e.hlt = hlt_m; e.cnt = cnt_m;
    sb.push_back(e);

    ex_valid = 1'b1; ex_instr = instr; ex_regwrt = regwrt; ex_rd = rd; ex_alu = alu;
    ex_memread = mrd; ex_memwrt = mwr; ex_st_data = st; ex_hlt = is_hlt;
    if (!(mrd | mwr)) begin
      dmem_ack = 1'($urandom_range(0, 1));   // stray ack must be ignored
      dmem_rdata = 16'($urandom);
      @(negedge clk);
      chk("nonmem_req", dmem_req, 0);
      chk("nonmem_stall", mem_stall, 0);
      chk("nonmem_err", dmem_err, err_m);
      @(posedge clk); #1;
    end else begin
      noack = 0;
      for (int c = 0; c <= ack_dly; c++) begin
        if (c == 0) begin
          dmem_ack = 1'($urandom_range(0, 1));   // ack in the request cycle is ignored
          dmem_rdata = 16'($urandom);
        end else begin
          dmem_ack = (c == ack_dly);
          dmem_rdata = (c == ack_dly) ? rdv : 16'($urandom);
        end
        @(negedge clk);
        chk("mem_req", dmem_req, 1);
        chk("mem_stall", mem_stall, (c != ack_dly));
        chk("mem_addr", dmem_addr, alu);
        chk("mem_wr", dmem_wr, mwr);
        if (mwr) chk("mem_wdata", dmem_wdata, st);
        chk("mem_err", dmem_err, err_m);
        @(posedge clk); #1;
        if (c > 0 && c != ack_dly) begin
          noack++;
          if (noack == 255) err_m = 1'b1;
        end
      end
    end
    ex_valid = 1'b0; ex_hlt = 1'b0; dmem_ack = 1'b0;
  endtask

  // Invalid EX slot with junk fields: must yield a bubble and no request
  task automatic empty_slot();
    ex_valid = 1'b0; ex_instr = rnd_instr(); ex_regwrt = 1'b1; ex_alu = 16'($urandom);
    ex_memread = 1'($urandom_range(0, 1)); ex_memwrt = 1'($urandom_range(0, 1));
    ex_hlt = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("empty_req", dmem_req, 0);
    chk("empty_stall", mem_stall, 0);
    @(posedge clk); #1;
    ex_hlt = 1'b0; dmem_ack = 1'b0;
  endtask

  // Monitor: every non-bubble WB bundle is one retirement
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_regdata = 16'h0;
      end else if (Instr_WB != 16'h0) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_retire: got Instr_WB 0x%0h, expected none", Instr_WB);
        end else begin
          e = sb.pop_front();
          chk("wb_instr", Instr_WB, e.instr);
          chk("wb_regwrt", RegWrt_WB, e.regwrt);
          chk("wb_rd", Rd_WB, e.rd);
          chk("wb_regdata", RegWrt_Data_WB, e.regdata);
          chk("wb_memread", MemRead_WB, e.mrd);
          chk("wb_memwrt", MemWrt_WB, e.mwr);
          if (e.chk_a) chk("wb_memaddr", MemAddr_WB, e.addr);
          if (e.chk_w) chk("wb_memwdata", MemWrt_Data_WB, e.wdata);
          if (e.chk_r) chk("wb_memrdata", MemRead_Data_WB, e.rdata);
          chk("wb_hlt", hlt, e.hlt);
          chk("wb_inst_count", inst_count, e.cnt);
          last_regdata = e.regdata;
        end
      end else begin
        chk("bubble_ctrl", {RegWrt_WB, MemRead_WB, MemWrt_WB}, 0);
        chk("bubble_hold", RegWrt_Data_WB, last_regdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_instr = 0; ex_regwrt = 0; ex_rd = 0; ex_alu = 0;
    ex_memread = 0; ex_memwrt = 0; ex_st_data = 0; ex_hlt = 0; dmem_rdata = 0; dmem_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {dmem_req, mem_stall, dmem_wr, dmem_err, hlt, RegWrt_WB, MemRead_WB, MemWrt_WB}, 0);
    chk("rst_instr", Instr_WB, 0);
    chk("rst_count", inst_count, 0);
    chk("rst_regdata", RegWrt_Data_WB, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD r3 = 0x0042
    issue(16'h1234, 1'b1, 4'd3, 16'h0042, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    // Load from 0x0100, ack on third BUSY cycle
    mem_m[16'h0100] = 16'hBEEF;
    issue(16'h8105, 1'b1, 4'd5, 16'h0100, 1'b1, 1'b0, 16'h0, 1'b0, 3);
    // Store 0x1234 to 0x0020, ack one cycle later
    issue(16'h9020, 1'b0, 4'd0, 16'h0020, 1'b0, 1'b1, 16'h1234, 1'b0, 1);
    // Read it back with the minimum latency
    issue(16'h8220, 1'b1, 4'd2, 16'h0020, 1'b1, 1'b0, 16'h0, 1'b0, 1);

    // Randomized instruction mix
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: issue(rnd_instr(), 1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom),
                 1'b0, 1'b0, 16'($urandom), 1'b0, 0);
        1: issue(rnd_instr(), 1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom_range(0, 15)),
                 1'b1, 1'b0, 16'($urandom), 1'b0, int'($urandom_range(1, 5)));
        2: issue(rnd_instr(), 1'b0, 4'($urandom), 16'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 1'b0, int'($urandom_range(1, 5)));
        default: empty_slot();
      endcase
    end

    // Ack withheld past the timeout; completes normally afterwards
    issue(16'h8330, 1'b1, 4'd7, 16'h0030, 1'b1, 1'b0, 16'h0, 1'b0, 300);
    @(negedge clk);
    chk("timeout_sticky", dmem_err, 1);
    @(posedge clk); #1;

    // Reset asserted in the middle of a BUSY access
    ex_valid = 1'b1; ex_instr = 16'h8440; ex_regwrt = 1'b1; ex_rd = 4'd4; ex_alu = 16'h0055;
    ex_memread = 1'b1; ex_memwrt = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    chk("prerst_req", dmem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("prerst_stall", mem_stall, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_err", dmem_err, 0);
    chk("midrst_count", inst_count, 0);
    @(negedge clk); #2;
    ex_valid = 1'b0;
    rst_n = 1'b1;
    cnt_m = 0; err_m = 1'b0; hlt_m = 1'b0;
    @(posedge clk); #1;
    issue(16'h1111, 1'b1, 4'd1, 16'h0777, 1'b0, 1'b0, 16'h0, 1'b0, 0);
    for (int i = 0; i < 10; i++)
      issue(rnd_instr(), 1'b1, 4'($urandom), 16'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0, int'($urandom_range(1, 3)));

    // HLT, then further instructions must be ignored
    issue(16'hF000, 1'b0, 4'd0, 16'h0ABC, 1'b0, 1'b0, 16'h0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      ex_valid = 1'b1; ex_instr = rnd_instr(); ex_regwrt = 1'b1; ex_rd = 4'd6;
      ex_alu = 16'h0010; ex_memread = (i % 2 == 1); ex_memwrt = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halted_req", dmem_req, 0);
      chk("halted_stall", mem_stall, 0);
      chk("halted_hlt", hlt, 1);
      chk("halted_regwrt", RegWrt_WB, 0);
      chk("halted_count", inst_count, cnt_m);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 16-bit 5-stage pipelined cpu.
- Takes the EX/MEM bundle and runs the load or store on a multi-cycle data-memory req/ack port.
- Stalls the upstream pipe while the access is outstanding.
- Drives the registered write-back bundle: register-file write, trace and halt signals, and a retired-instruction counter.

Parameters:
- DW, 16, datapath and address width.
- RW, 4, register-specifier width.
- ACK_TIMEOUT, 255, cycles waiting for dmem_ack before the sticky error flag sets (8-bit counter).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_instr  in  16  instruction word
- ex_regwrt  in  1  instruction writes the register file
- ex_rd  in  RW  destination register
- ex_alu  in  DW  ALU result; memory address for loads/stores
- ex_memread  in  1  load
- ex_memwrt  in  1  store
- ex_st_data  in  DW  store data, already forwarded
- ex_hlt  in  1  HLT instruction
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- dmem_req  out  1  memory request
- dmem_wr  out  1  1 = write
- dmem_addr  out  DW  memory address
- dmem_wdata  out  DW  write data
- dmem_rdata  in  DW  read data, valid with ack
- dmem_ack  in  1  access complete
- Instr_WB  out  16  retiring instruction
- RegWrt_WB  out  1  register-file write enable
- Rd_WB  out  RW  write register
- RegWrt_Data_WB  out  DW  write data
- MemRead_WB  out  1  retiring load
- MemWrt_WB  out  1  retiring store
- MemAddr_WB  out  DW  access address
- MemWrt_Data_WB  out  DW  stored value
- MemRead_Data_WB  out  DW  loaded value
- hlt  out  1  halt reached WB; sticky
- inst_count  out  32  retired instructions
- dmem_err  out  1  sticky ack-timeout flag

Behaviour:
- Reset: async, immediate. All outputs 0; state IDLE; counters 0; dmem_req drops mid-access and the access is abandoned.
- memop = ex_valid & (ex_memread | ex_memwrt). If both read and write are set, the access is a write and MemRead_WB = 0.
- FSM states IDLE, BUSY, HALTED.
- IDLE, non-memop valid: WB bundle loads next edge (1-cycle latency). MemRead_Data_WB = 0, MemWrt_Data_WB = 0. RegWrt_Data_WB = ex_alu.
- IDLE, memop: combinationally assert dmem_req with dmem_addr = ex_alu, dmem_wr, dmem_wdata = ex_st_data. Also assert mem_stall. Go to BUSY; the WB bundle loads a bubble.
- BUSY: hold req/addr/wr/wdata stable; upstream holds the EX/MEM bundle. mem_stall = ~dmem_ack.
- BUSY, on ack: WB bundle loads. For a load, RegWrt_Data_WB = MemRead_Data_WB = dmem_rdata. MemAddr_WB = ex_alu; MemWrt_Data_WB = ex_st_data for a store. Go to IDLE, dmem_req = 0, mem_stall = 0 in the same cycle.
- dmem_ack is ignored outside BUSY, and in the first request cycle.
- Minimum load/store latency is 2 cycles.
- Bubble: Instr_WB = 0, RegWrt_WB = MemRead_WB = MemWrt_WB = 0, other data outputs hold.
- Invalid ex slot also produces a bubble.
- Halt: valid ex_hlt in IDLE retires next edge with hlt = 1. State goes to HALTED.
- HALTED: all further inputs ignored, bubbles only, no requests, hlt stays 1 until reset.
- A halt never carries a memop.
- Timeout: 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
- Reaching ACK_TIMEOUT sets dmem_err, sticky. The stage stays in BUSY (no forced completion).
- inst_count increments on each edge where the loaded WB bundle has RegWrt_WB | MemWrt_WB | hlt-entry. Halt counts once. Wraps at 2^32.

Decomposition:
- Package cpu_pkg: DW, RW, FSM state enum, bubble constants, HALT opcode.
- One sub-module, mem_access_fsm: IDLE/BUSY/HALTED, dmem handshake, stall and timeout.
- The top level holds the WB registers and inst_count.

Test Plan:
- ADD r3 (ex_alu = 0x0042), no memop -> next edge RegWrt_WB = 1, Rd_WB = 3, RegWrt_Data_WB = 0x0042, mem_stall never high, inst_count = 1.
- Load from 0x0100, ack on 3rd BUSY cycle with rdata 0xBEEF -> dmem_req high 4 cycles, mem_stall high 3 cycles. Then RegWrt_Data_WB = MemRead_Data_WB = 0xBEEF, MemRead_WB = 1, MemAddr_WB = 0x0100.
- Store 0x1234 to 0x0020, ack 1 cycle later -> dmem_wr = 1, MemWrt_WB = 1, MemWrt_Data_WB = 0x1234, RegWrt_WB = 0, inst_count + 1.
- HLT, then ADD and LW presented -> hlt = 1 permanently, no dmem_req, RegWrt_WB stays 0, inst_count + 1 only.
- Load with no ack for 255 cycles -> dmem_err = 1, mem_stall still 1. Later ack completes the load normally.
- rst_n low mid-BUSY -> dmem_req and mem_stall 0 immediately; after release, state IDLE and inst_count = 0.
